// File: rtl/qencoder_mc_pkg.sv
// Shared definitions for the multi-channel quadrature encoder interface:
// decode mode codes, transition classification and the per-update step decode.
package qencoder_mc_pkg;

  // Decode mode codes; 2'b11 behaves as x4.
  localparam logic [1:0] MODE_X1 = 2'b00;
  localparam logic [1:0] MODE_X2 = 2'b01;
  localparam logic [1:0] MODE_X4 = 2'b10;

  // Classification of a filtered {B,A} update.
  typedef enum logic [1:0] {
    TR_NONE    = 2'd0,
    TR_FWD     = 2'd1,
    TR_REV     = 2'd2,
    TR_ILLEGAL = 2'd3
  } tr_kind_e;

  // Result of decoding one filtered update in the selected mode.
  typedef struct packed {
    logic count;    // this update moves the position
    logic up;       // direction of the move (1 = forward)
    logic illegal;  // A and B changed together
  } step_t;

  // Forward order of {B,A} is 00 -> 01 -> 11 -> 10 -> 00 (A leads B).
  function automatic tr_kind_e classify(input logic [1:0] prev_ba, input logic [1:0] next_ba);
    tr_kind_e kind;
    kind = TR_NONE;
    case ({prev_ba, next_ba})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: kind = TR_FWD;
      4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: kind = TR_REV;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: kind = TR_ILLEGAL;
      default:                                kind = TR_NONE;
    endcase
    return kind;
  endfunction

  // x4 counts every legal edge, x2 only edges where A toggles,
  // x1 only the 00<->01 pair.
  function automatic step_t decode(input logic [1:0] prev_ba, input logic [1:0] next_ba,
                                   input logic [1:0] mode);
    step_t    s;
    tr_kind_e kind;
    logic     legal;
    logic     a_changed;
    kind      = classify(prev_ba, next_ba);
    legal     = (kind == TR_FWD) || (kind == TR_REV);
    a_changed = prev_ba[0] ^ next_ba[0];
    s.up      = (kind == TR_FWD);
    s.illegal = (kind == TR_ILLEGAL);
    case (mode)
      MODE_X1: s.count = ({prev_ba, next_ba} == 4'b00_01) || ({prev_ba, next_ba} == 4'b01_00);
      MODE_X2: s.count = legal && a_changed;
      default: s.count = legal;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/qencoder_mc_channel.sv
// One encoder channel: synchronizers, per-bit glitch filters, transition
// decoder, position/direction/error registers and the velocity accumulator.
module qencoder_mc_channel
  import qencoder_mc_pkg::*;
#(
  parameter int NB   = 32,
  parameter int FILT = 2
) (
  input  logic          clk,
  input  logic          i_reset,
  input  logic          i_enable,
  input  logic [1:0]    i_mode,
  input  logic [1:0]    i_enc,       // {B,A}, asynchronous
  input  logic          i_index,     // Z, asynchronous
  input  logic          i_index_en,
  input  logic          i_clear,
  input  logic          i_vel_load,  // terminal cycle of the velocity window
  output logic [NB-1:0] o_position,
  output logic          o_dir,
  output logic          o_error,
  output logic [NB-1:0] o_velocity
);

  localparam int CW = (FILT < 1) ? 1 : $clog2(FILT + 1);

  // Bit order in the input path: 0 = A, 1 = B, 2 = Z.
  logic [2:0]    sync1_reg;
  logic [2:0]    sync2_reg;
  logic [2:0]    filt_vec;
  logic [2:0]    prev_vec;
  step_t         step;
  logic          z_rise;
  logic          index_hit;
  logic          apply;
  logic [NB-1:0] delta;
  logic [NB-1:0] pos_reg;
  logic          dir_reg;
  logic          err_reg;
  logic [NB-1:0] acc_reg;
  logic [NB-1:0] vel_reg;

  // Two-stage synchronizer; keeps sampling through reset.
  always_ff @(posedge clk) begin
    sync1_reg <= {i_index, i_enc};
    sync2_reg <= sync1_reg;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_bit
      if (FILT == 0) begin : g_bypass
        logic f_reg;
        logic p_reg;
        // Unfiltered path; prev tracks the synchronized value during reset so
        // that release never shows a transition.
        always_ff @(posedge clk) begin
          f_reg <= sync2_reg[gi];
          p_reg <= i_reset ? sync2_reg[gi] : f_reg;
        end
        assign filt_vec[gi] = f_reg;
        assign prev_vec[gi] = p_reg;
      end else begin : g_filter
        logic          f_reg;
        logic          p_reg;
        logic          cand_reg;
        logic [CW-1:0] cnt_reg;
        // Accept a new level once it has been seen FILT times in a row after
        // its first observation; any return to the filtered level restarts.
        always_ff @(posedge clk) begin
          cand_reg <= sync2_reg[gi];
          if (i_reset) begin
            f_reg   <= sync2_reg[gi];
            p_reg   <= sync2_reg[gi];
            cnt_reg <= '0;
          end else begin
            p_reg <= f_reg;
            if (sync2_reg[gi] == f_reg) begin
              cnt_reg <= '0;
            end else if (sync2_reg[gi] != cand_reg) begin
              cnt_reg <= CW'(1);
            end else if (cnt_reg == CW'(FILT)) begin
              f_reg   <= sync2_reg[gi];
              cnt_reg <= '0;
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end
        end
        assign filt_vec[gi] = f_reg;
        assign prev_vec[gi] = p_reg;
      end
    end
  endgenerate

  // Decode the filtered update seen in the previous cycle.
  always_comb begin
    step      = decode(prev_vec[1:0], filt_vec[1:0], i_mode);
    z_rise    = ~prev_vec[2] & filt_vec[2];
    index_hit = i_enable & i_index_en & z_rise;
    apply     = i_enable & step.count & ~i_clear & ~index_hit;
    delta     = '0;
    if (apply) begin
      delta = step.up ? NB'(1) : '1;
    end
  end

  // Position, direction and sticky error: reset > clear > index > count.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      pos_reg <= '0;
      dir_reg <= 1'b0;
      err_reg <= 1'b0;
    end else if (i_clear) begin
      pos_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      if (index_hit) begin
        pos_reg <= '0;
      end else if (apply) begin
        pos_reg <= pos_reg + delta;
        dir_reg <= step.up;
      end
      if (i_enable && step.illegal) begin
        err_reg <= 1'b1;
      end
    end
  end

  // Velocity: accumulate applied counts and publish at the window end.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      acc_reg <= '0;
      vel_reg <= '0;
    end else if (!i_enable) begin
      acc_reg <= '0;
    end else if (i_vel_load) begin
      vel_reg <= acc_reg + delta;
      acc_reg <= '0;
    end else begin
      acc_reg <= acc_reg + delta;
    end
  end

  assign o_position = pos_reg;
  assign o_dir      = dir_reg;
  assign o_error    = err_reg;
  assign o_velocity = vel_reg;

endmodule

// File: rtl/qencoder_mc.sv
// Multi-channel quadrature encoder interface: NCH independent channels plus a
// shared velocity window counter.
module qencoder_mc
  import qencoder_mc_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int NB      = 32,
  parameter int FILT    = 2,
  parameter int VEL_WIN = 1000
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic [2*NCH-1:0]  i_encoder,
  input  logic [NCH-1:0]    i_index,
  input  logic [NCH-1:0]    i_index_en,
  input  logic [NCH-1:0]    i_clear,
  input  logic [1:0]        i_mode,
  output logic [NCH*NB-1:0] o_position,
  output logic [NCH-1:0]    o_dir,
  output logic [NCH-1:0]    o_error,
  output logic [NCH*NB-1:0] o_velocity,
  output logic              o_vel_valid
);

  localparam int WW = (VEL_WIN < 2) ? 1 : $clog2(VEL_WIN);

  logic [WW-1:0] win_reg;
  logic          win_term;
  logic          vel_load;
  logic          valid_reg;

  assign win_term = (win_reg == WW'(VEL_WIN - 1));
  assign vel_load = i_enable & win_term;

  // Window counter runs 0..VEL_WIN-1 while enabled; the valid pulse follows
  // the terminal cycle together with the freshly loaded velocity words.
  always_ff @(posedge clk) begin
    if (i_reset || !i_enable) begin
      win_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      win_reg   <= win_term ? '0 : win_reg + WW'(1);
      valid_reg <= win_term;
    end
  end

  assign o_vel_valid = valid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      qencoder_mc_channel #(
        .NB   (NB),
        .FILT (FILT)
      ) u_channel (
        .clk        (clk),
        .i_reset    (i_reset),
        .i_enable   (i_enable),
        .i_mode     (i_mode),
        .i_enc      (i_encoder[2*gi +: 2]),
        .i_index    (i_index[gi]),
        .i_index_en (i_index_en[gi]),
        .i_clear    (i_clear[gi]),
        .i_vel_load (vel_load),
        .o_position (o_position[gi*NB +: NB]),
        .o_dir      (o_dir[gi]),
        .o_error    (o_error[gi]),
        .o_velocity (o_velocity[gi*NB +: NB])
      );
    end
  endgenerate

endmodule

// File: tb/tb_qencoder_mc.sv
// Directed bench for qencoder_mc: main instance NCH=2 NB=16 FILT=2 VEL_WIN=100,
// plus a narrow NB=4 FILT=0 instance for the signed wrap boundary.
module tb_qencoder_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_reset;
  logic        i_enable;
  logic [3:0]  enc;
  logic [1:0]  idx;
  logic [1:0]  idx_en;
  logic [1:0]  clr;
  logic [1:0]  mode;
  logic [31:0] position;
  logic [31:0] velocity;
  logic [1:0]  dir;
  logic [1:0]  err;
  logic        vel_valid;

  logic [1:0]  w_enc;
  logic        w_index;
  logic        w_index_en;
  logic        w_clear;
  logic [3:0]  w_pos;
  logic [3:0]  w_vel;
  logic        w_dir;
  logic        w_err;
  logic        w_valid;

  logic [15:0] p0, p1, v0, v1;
  assign p0 = position[15:0];
  assign p1 = position[31:16];
  assign v0 = velocity[15:0];
  assign v1 = velocity[31:16];

  int checks   = 0;
  int failures = 0;

  logic [1:0]  cur0 = 2'b00;
  logic [1:0]  cur1 = 2'b00;
  logic [1:0]  wcur = 2'b00;
  logic [15:0] exp0 = 16'h0000;

  qencoder_mc #(.NCH(2), .NB(16), .FILT(2), .VEL_WIN(100)) dut (
    .clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_encoder(enc),
    .i_index(idx), .i_index_en(idx_en), .i_clear(clr), .i_mode(mode),
    .o_position(position), .o_dir(dir), .o_error(err),
    .o_velocity(velocity), .o_vel_valid(vel_valid)
  );

  qencoder_mc #(.NCH(1), .NB(4), .FILT(0), .VEL_WIN(4)) dut_w (
    .clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_encoder(w_enc),
    .i_index(w_index), .i_index_en(w_index_en), .i_clear(w_clear), .i_mode(mode),
    .o_position(w_pos), .o_dir(w_dir), .o_error(w_err),
    .o_velocity(w_vel), .o_vel_valid(w_valid)
  );

  function automatic logic [1:0] fwd(input logic [1:0] ba);
    case (ba)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev(input logic [1:0] ba);
    case (ba)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // Inputs change and outputs are sampled on falling edges.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    i_reset = 1'b1; i_enable = 1'b1; enc = '0; idx = '0; idx_en = '0; clr = '0;
    mode = 2'b10; w_enc = '0; w_index = 1'b0; w_index_en = 1'b0; w_clear = 1'b0;
    cyc(6);
    checks++; if (position !== 32'h0) begin failures++; $display("FAIL reset_pos got=%h exp=%h", position, 32'h0); end
    checks++; if (dir !== 2'b00) begin failures++; $display("FAIL reset_dir got=%b exp=00", dir); end
    checks++; if (err !== 2'b00) begin failures++; $display("FAIL reset_err got=%b exp=00", err); end
    checks++; if (velocity !== 32'h0) begin failures++; $display("FAIL reset_vel got=%h exp=0", velocity); end
    checks++; if (vel_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", vel_valid); end
    i_reset = 1'b0;
    cyc(10);
    checks++; if (position !== 32'h0 || err !== 2'b00) begin failures++; $display("FAIL release_quiet pos=%h err=%b exp pos=0 err=00", position, err); end
    $display("reset done pos=%h err=%b", position, err);
  endtask

  // Input driven mid-cycle, sampled at edge 0, visible after edge 5.
  task automatic test_x4_forward;
    mode = 2'b10;
    for (int s = 0; s < 4; s++) begin
      cur0 = fwd(cur0);
      enc[1:0] = cur0;
      cyc(5);
      checks++; if (p0 !== exp0) begin failures++; $display("FAIL x4_early step=%0d got=%h exp=%h", s, p0, exp0); end
      exp0 = exp0 + 16'd1;
      cyc(1);
      checks++; if (p0 !== exp0) begin failures++; $display("FAIL x4_step step=%0d got=%h exp=%h", s, p0, exp0); end
      $display("x4 ch0 ba=%b pos=%h", cur0, p0);
      cyc(2);
    end
    checks++; if (p0 !== 16'd4) begin failures++; $display("FAIL x4_total got=%h exp=0004", p0); end
    checks++; if (dir[0] !== 1'b1) begin failures++; $display("FAIL x4_dir got=%b exp=1", dir[0]); end
    checks++; if (p1 !== 16'd0) begin failures++; $display("FAIL x4_ch1_idle got=%h exp=0000", p1); end
  endtask

  task automatic test_x1_x2_reverse;
    logic [15:0] x1_exp [4] = '{16'h0000, 16'h0000, 16'h0000, 16'hFFFF};
    logic [15:0] x2_exp [4] = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFE};
    mode = 2'b00;
    for (int s = 0; s < 4; s++) begin
      cur1 = rev(cur1);
      enc[3:2] = cur1;
      cyc(8);
      checks++; if (p1 !== x1_exp[s]) begin failures++; $display("FAIL x1_rev step=%0d got=%h exp=%h", s, p1, x1_exp[s]); end
      $display("x1 ch1 ba=%b pos=%h", cur1, p1);
    end
    clr[1] = 1'b1; cyc(1); clr[1] = 1'b0; cyc(1);
    checks++; if (p1 !== 16'h0) begin failures++; $display("FAIL clear_ch1 got=%h exp=0000", p1); end
    mode = 2'b01;
    for (int s = 0; s < 4; s++) begin
      cur1 = rev(cur1);
      enc[3:2] = cur1;
      cyc(8);
      checks++; if (p1 !== x2_exp[s]) begin failures++; $display("FAIL x2_rev step=%0d got=%h exp=%h", s, p1, x2_exp[s]); end
      $display("x2 ch1 ba=%b pos=%h", cur1, p1);
    end
    checks++; if (dir[1] !== 1'b0) begin failures++; $display("FAIL rev_dir got=%b exp=0", dir[1]); end
    checks++; if (p0 !== exp0) begin failures++; $display("FAIL ch0_isolated got=%h exp=%h", p0, exp0); end
  endtask

  task automatic test_wrap;
    mode = 2'b10;
    clr[0] = 1'b1; cyc(1); clr[0] = 1'b0; cyc(1);
    checks++; if (p0 !== 16'h0) begin failures++; $display("FAIL clear_ch0 got=%h exp=0000", p0); end
    cur0 = rev(cur0);
    enc[1:0] = cur0;
    cyc(8);
    checks++; if (p0 !== 16'hFFFF) begin failures++; $display("FAIL wrap_neg got=%h exp=FFFF", p0); end
    checks++; if (dir[0] !== 1'b0) begin failures++; $display("FAIL wrap_neg_dir got=%b exp=0", dir[0]); end
    $display("wrap ch0 pos=%h", p0);
    for (int s = 0; s < 7; s++) begin
      wcur = fwd(wcur); w_enc = wcur; cyc(2);
    end
    cyc(5);
    checks++; if (w_pos !== 4'h7) begin failures++; $display("FAIL narrow_max got=%h exp=7", w_pos); end
    wcur = fwd(wcur); w_enc = wcur; cyc(5);
    checks++; if (w_pos !== 4'h8) begin failures++; $display("FAIL narrow_wrap_pos got=%h exp=8", w_pos); end
    checks++; if (w_dir !== 1'b1) begin failures++; $display("FAIL narrow_dir_fwd got=%b exp=1", w_dir); end
    wcur = rev(wcur); w_enc = wcur; cyc(5);
    checks++; if (w_pos !== 4'h7) begin failures++; $display("FAIL narrow_wrap_neg got=%h exp=7", w_pos); end
    checks++; if (w_dir !== 1'b0) begin failures++; $display("FAIL narrow_dir_rev got=%b exp=0", w_dir); end
    $display("narrow pos=%h", w_pos);
  endtask

  task automatic test_illegal_clear;
    for (int s = 0; s < 3; s++) begin
      cur0 = fwd(cur0); enc[1:0] = cur0; cyc(8);
    end
    checks++; if (p0 !== 16'd2) begin failures++; $display("FAIL pre_illegal got=%h exp=0002", p0); end
    cur0 = 2'b00;
    enc[1:0] = cur0;
    cyc(8);
    checks++; if (err[0] !== 1'b1) begin failures++; $display("FAIL illegal_err got=%b exp=1", err[0]); end
    checks++; if (p0 !== 16'd2) begin failures++; $display("FAIL illegal_pos got=%h exp=0002", p0); end
    checks++; if (dir[0] !== 1'b1) begin failures++; $display("FAIL illegal_dir got=%b exp=1", dir[0]); end
    checks++; if (err[1] !== 1'b0) begin failures++; $display("FAIL illegal_other_ch got=%b exp=0", err[1]); end
    $display("illegal ch0 err=%b pos=%h", err[0], p0);
    clr[0] = 1'b1; cyc(1); clr[0] = 1'b0; cyc(1);
    checks++; if (err[0] !== 1'b0) begin failures++; $display("FAIL clear_err got=%b exp=0", err[0]); end
    checks++; if (p0 !== 16'h0) begin failures++; $display("FAIL clear_pos got=%h exp=0000", p0); end
  endtask

  task automatic test_glitch;
    enc[0] = 1'b1; cyc(1); enc[0] = 1'b0; cyc(10);
    checks++; if (p0 !== 16'h0) begin failures++; $display("FAIL glitch_pos got=%h exp=0000", p0); end
    checks++; if (err[0] !== 1'b0) begin failures++; $display("FAIL glitch_err got=%b exp=0", err[0]); end
    $display("glitch ch0 pos=%h", p0);
  endtask

  task automatic test_index;
    cur0 = fwd(cur0); enc[1:0] = cur0; cyc(8);
    checks++; if (p0 !== 16'd1) begin failures++; $display("FAIL idx_pre got=%h exp=0001", p0); end
    idx_en[0] = 1'b1;
    cur0 = fwd(cur0); enc[1:0] = cur0; idx[0] = 1'b1;
    cyc(8);
    checks++; if (p0 !== 16'd0) begin failures++; $display("FAIL idx_coincident got=%h exp=0000", p0); end
    idx[0] = 1'b0; cyc(8); idx_en[0] = 1'b0;
    checks++; if (p0 !== 16'd0) begin failures++; $display("FAIL idx_fall got=%h exp=0000", p0); end
    cur0 = fwd(cur0); enc[1:0] = cur0; cyc(8);
    checks++; if (p0 !== 16'd1) begin failures++; $display("FAIL idx_post got=%h exp=0001", p0); end
    idx[0] = 1'b1; cyc(8); idx[0] = 1'b0; cyc(8);
    checks++; if (p0 !== 16'd1) begin failures++; $display("FAIL idx_disabled got=%h exp=0001", p0); end
    $display("index ch0 pos=%h", p0);
  endtask

  task automatic test_velocity;
    int nvalid = 0;
    int last_t = 0;
    for (int t = 0; t < 360; t++) begin
      if (t % 10 == 0) begin
        cur0 = fwd(cur0); enc[1:0] = cur0;
      end
      cyc(1);
      if (vel_valid === 1'b1) begin
        nvalid++;
        if (nvalid >= 2) begin
          checks++; if (v0 !== 16'd10) begin failures++; $display("FAIL vel_ch0 pulse=%0d got=%h exp=000a", nvalid, v0); end
          checks++; if (v1 !== 16'd0) begin failures++; $display("FAIL vel_ch1 pulse=%0d got=%h exp=0000", nvalid, v1); end
          checks++; if (t - last_t != 100) begin failures++; $display("FAIL vel_period pulse=%0d got=%0d exp=100", nvalid, t - last_t); end
        end
        $display("vel pulse=%0d t=%0d v0=%h v1=%h", nvalid, t, v0, v1);
        last_t = t;
      end
    end
    checks++; if (nvalid < 3) begin failures++; $display("FAIL vel_pulses got=%0d exp>=3", nvalid); end
  endtask

  task automatic test_reset_mid_window;
    for (int s = 0; s < 4 && cur0 != 2'b11; s++) begin
      cur0 = fwd(cur0); enc[1:0] = cur0; cyc(8);
    end
    cyc(37);
    i_reset = 1'b1;
    cyc(3);
    checks++; if (position !== 32'h0) begin failures++; $display("FAIL mid_reset_pos got=%h exp=0", position); end
    checks++; if (dir !== 2'b00) begin failures++; $display("FAIL mid_reset_dir got=%b exp=00", dir); end
    checks++; if (velocity !== 32'h0) begin failures++; $display("FAIL mid_reset_vel got=%h exp=0", velocity); end
    checks++; if (vel_valid !== 1'b0 || err !== 2'b00) begin failures++; $display("FAIL mid_reset_flags valid=%b err=%b exp 0/00", vel_valid, err); end
    i_reset = 1'b0;
    cyc(20);
    checks++; if (p0 !== 16'h0) begin failures++; $display("FAIL post_reset_pos got=%h exp=0000", p0); end
    checks++; if (err[0] !== 1'b0) begin failures++; $display("FAIL post_reset_err got=%b exp=0", err[0]); end
    $display("mid reset ch0 ba=%b pos=%h err=%b", cur0, p0, err[0]);
  endtask

  initial begin
    test_reset;
    test_x4_forward;
    test_x1_x2_reverse;
    test_wrap;
    test_illegal_clear;
    test_glitch;
    test_index;
    test_velocity;
    test_reset_mid_window;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
